vfd_scan_engine: RTL and testbench

VFD_SCAN_ENGINE -- requirements
Module: vfd_scan_engine

---
 rtl/vfd_scan_engine.sv | 136 +++++++++++++
 tb/tb_vfd_scan_engine.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vfd_scan_engine.sv
// VFD grid scanner: per grid period it latches, shifts pixel bit-planes plus grid-select bits, then holds.
// Outputs decode from registered state; SOUT passes MEM_DATA through in phase 0 (one-clock read latency), no backpressure.
module vfd_scan_engine #(
  parameter int N_GRID   = 52,
  parameter int N_LANE   = 3,
  parameter int PIX_BITS = 234,
  parameter int PERIOD   = 3846,
  parameter int LAT_CYC  = 3,
  parameter int BLK_CYC  = 120,
  parameter int DIM_STEP = 8,
  parameter int GCP_W    = 3,
  parameter int ADDR_W   = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [7:0]                dim,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_rd,
  input  logic [N_LANE-1:0]         mem_data,
  output logic [N_LANE-1:0]         sout,
  output logic                      sck,
  output logic                      lat,
  output logic                      blk,
  output logic                      gcp,
  output logic [$clog2(N_GRID)-1:0] grid,
  output logic                      frame
);

  localparam int N_BITS = PIX_BITS + N_GRID;
  localparam int P_W    = $clog2(PERIOD);
  localparam int SC_W   = $clog2(2 * N_BITS + 1);
  localparam int G_W    = $clog2(N_GRID);
  localparam int GSTEP  = PERIOD >> N_LANE;

  typedef enum logic [1:0] {IDLE, LATCH, SHIFT, HOLD} state_t;

  state_t            state_q, state_nxt;
  logic [P_W-1:0]    p_q;
  logic [G_W-1:0]    grid_q;
  logic [ADDR_W-1:0] base_q;
  logic [SC_W-1:0]   sc_q;
  logic [P_W-1:0]    blk_len_q;
  logic [N_LANE-1:0] sout_q;

  logic              active, in_shift, ph0, ph1;
  logic [SC_W-2:0]   bit_idx;
  logic [N_LANE-1:0] sout_c;
  logic [31:0]       b_raw;
  logic [P_W-1:0]    b_sat, blk_lim;
  logic              gcp_c;
  int                gpos;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (en) state_nxt = LATCH;
      LATCH:   if (p_q == P_W'(LAT_CYC - 1)) state_nxt = SHIFT;
      SHIFT:   if (sc_q == SC_W'(2 * N_BITS)) state_nxt = HOLD;
      HOLD:    if (p_q == P_W'(PERIOD - 1)) state_nxt = LATCH;
      default: state_nxt = IDLE;
    endcase
  end

  // sc_q counts clocks inside SHIFT: even = read slot / phase 1, odd = phase 0 of bit sc_q>>1
  always_comb begin
    active   = (state_q != IDLE);
    in_shift = (state_q == SHIFT);
    ph0      = in_shift && sc_q[0];
    ph1      = in_shift && !sc_q[0] && (sc_q != '0);
    bit_idx  = sc_q[SC_W-1:1];
    gpos     = int'(bit_idx) - PIX_BITS;
    sout_c   = '0;
    if (ph0) begin
      if (int'(bit_idx) < PIX_BITS)
        sout_c = mem_data;
      else if (gpos == int'(grid_q) || gpos == int'(grid_q) + 1)
        sout_c = '1;
    end
  end

  always_comb begin
    b_raw   = 32'(BLK_CYC) + 32'(dim) * 32'(DIM_STEP);
    b_sat   = (b_raw > 32'(PERIOD - 1)) ? P_W'(PERIOD - 1) : b_raw[P_W-1:0];
    blk_lim = (p_q == '0) ? b_sat : blk_len_q;
    gcp_c   = 1'b0;
    for (int k = 1; k < (1 << N_LANE); k++) begin
      if (int'(p_q) >= k * GSTEP && int'(p_q) < k * GSTEP + GCP_W)
        gcp_c = 1'b1;
    end
  end

  always_comb begin
    lat      = (state_q == LATCH);
    blk      = active && (p_q < blk_lim);
    gcp      = active && gcp_c;
    frame    = active && (p_q == '0) && (grid_q == '0);
    grid     = grid_q;
    sck      = ph1;
    mem_rd   = in_shift && !sc_q[0] && (int'(bit_idx) < PIX_BITS);
    mem_addr = base_q + ADDR_W'(bit_idx);
    sout     = ph0 ? sout_c : (ph1 ? sout_q : '0);
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state_q   <= IDLE;
      p_q       <= '0;
      grid_q    <= '0;
      base_q    <= '0;
      sc_q      <= '0;
      blk_len_q <= '0;
      sout_q    <= '0;
    end else begin
      state_q <= state_nxt;
      sc_q    <= (in_shift && state_nxt == SHIFT) ? sc_q + 1'b1 : '0;
      if (ph0) sout_q <= sout_c;
      if (active) begin
        if (p_q == '0) blk_len_q <= b_sat;
        if (p_q == P_W'(PERIOD - 1)) begin
          p_q <= '0;
          if (grid_q == G_W'(N_GRID - 1)) begin
            grid_q <= '0;
            base_q <= '0;
          end else begin
            grid_q <= grid_q + 1'b1;
            base_q <= base_q + ADDR_W'(PIX_BITS);
          end
        end else begin
          p_q <= p_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vfd_scan_engine.sv
// Bench for vfd_scan_engine: per-cycle reference model plus directed period captures with literal expectations.
module tb_vfd_scan_engine;

  localparam int NG = 4, NL = 2, PB = 6, PER = 64, LC = 3, BC = 10, DS = 2, GW = 3, AW = 14;
  localparam int NB = PB + NG;
  localparam int GSTEP = PER >> NL;

  logic          clk = 1'b0;
  logic          rst, en;
  logic [7:0]    dim;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [NL-1:0] mem_data = '0;
  logic [NL-1:0] sout;
  logic          sck, lat, blk, gcp, frame;
  logic [1:0]    grid;

  always #5 clk = ~clk;

  vfd_scan_engine #(
    .N_GRID(NG), .N_LANE(NL), .PIX_BITS(PB), .PERIOD(PER), .LAT_CYC(LC),
    .BLK_CYC(BC), .DIM_STEP(DS), .GCP_W(GW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .dim(dim),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .sout(sout), .sck(sck), .lat(lat), .blk(blk), .gcp(gcp),
    .grid(grid), .frame(frame)
  );

  // frame buffer: each pixel's bit-planes are the low address bits
  always @(posedge clk) if (mem_rd) mem_data <= mem_addr[NL-1:0];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  // reference model: position in period, grid, latched blank length
  bit cmp_on = 1'b0;
  bit m_act = 1'b0;
  int m_p = 0, m_g = 0, m_b = 0;
  int e_lat, e_blk, e_frame, e_gcp, e_sck, e_sout, e_rd, e_addr, bi, jj;

  always @(negedge clk) begin
    if (cmp_on) begin
      if (m_act && m_p == 0) m_b = (BC + int'(dim) * DS > PER - 1) ? PER - 1 : BC + int'(dim) * DS;
      e_lat   = (m_act && m_p < LC) ? 1 : 0;
      e_blk   = (m_act && m_p < m_b) ? 1 : 0;
      e_frame = (m_act && m_p == 0 && m_g == 0) ? 1 : 0;
      e_gcp   = 0;
      for (int k = 1; k < (1 << NL); k++)
        if (m_act && m_p >= k * GSTEP && m_p < k * GSTEP + GW) e_gcp = 1;
      e_sck  = 0;
      e_sout = 0;
      if (m_act && m_p >= LC + 1 && m_p <= LC + 2 * NB) begin
        bi    = (m_p - LC - 1) / 2;
        e_sck = (m_p - LC - 1) % 2;
        if (bi < PB) e_sout = (m_g * PB + bi) % (1 << NL);
        else begin
          jj     = bi - PB;
          e_sout = (jj == m_g || jj == m_g + 1) ? (1 << NL) - 1 : 0;
        end
      end
      e_rd   = (m_act && m_p >= LC && m_p < LC + 2 * PB && (m_p - LC) % 2 == 0) ? 1 : 0;
      e_addr = m_g * PB + (m_p - LC) / 2;
      chk("lat", lat, e_lat);
      chk("blk", blk, e_blk);
      chk("frame", frame, e_frame);
      chk("gcp", gcp, e_gcp);
      chk("sck", sck, e_sck);
      chk("sout", sout, e_sout);
      chk("mem_rd", mem_rd, e_rd);
      chk("grid", grid, m_act ? m_g : 0);
      if (e_rd == 1) chk("mem_addr", mem_addr, e_addr);
      if (!m_act) chk("mem_addr_idle", mem_addr, 0);
      if (rst || !en) begin
        m_act = 1'b0; m_p = 0; m_g = 0;
      end else if (!m_act) begin
        m_act = 1'b1; m_p = 0; m_g = 0;
      end else if (m_p == PER - 1) begin
        m_p = 0; m_g = (m_g + 1) % NG;
      end else begin
        m_p++;
      end
    end
  end

  int n_sck, n_blk, n_lat, n_gcp, f0, g0;
  int q_sout[$];
  int q_addr[$];
  int q_gcp[$];
  int exp_g1[10] = '{2, 3, 0, 1, 2, 3, 0, 3, 3, 0};
  int exp_g3[4]  = '{0, 0, 0, 3};

  task automatic align();
    logic prev;
    int   n;
    bit   found;
    prev = lat; n = 0; found = 1'b0;
    while (!found && n < 200) begin
      @(negedge clk);
      if (lat && !prev) found = 1'b1;
      prev = lat;
      n++;
    end
    if (!found) begin
      checks++; failures++;
      $display("FAIL align: no LAT rise within %0d cycles", n);
    end
  endtask

  // called at the p=0 sample; records one full period, switching DIM at p=30
  task automatic grab(input int new_dim);
    logic gprev;
    n_sck = 0; n_blk = 0; n_lat = 0; n_gcp = 0;
    q_sout.delete(); q_addr.delete(); q_gcp.delete();
    f0 = frame; g0 = grid; gprev = 1'b0;
    for (int p = 0; p < PER; p++) begin
      if (p > 0) @(negedge clk);
      if (sck) begin n_sck++; q_sout.push_back(int'(sout)); end
      if (blk) n_blk++;
      if (lat) n_lat++;
      if (gcp) n_gcp++;
      if (gcp && !gprev) q_gcp.push_back(p);
      gprev = gcp;
      if (mem_rd) q_addr.push_back(int'(mem_addr));
      if (p == 30) dim = 8'(new_dim);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_lat"}, lat, 0);   chk({tag, "_blk"}, blk, 0);
    chk({tag, "_gcp"}, gcp, 0);   chk({tag, "_sck"}, sck, 0);
    chk({tag, "_rd"}, mem_rd, 0); chk({tag, "_frame"}, frame, 0);
    chk({tag, "_sout"}, sout, 0); chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_grid"}, grid, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; dim = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    cmp_on = 1'b1;
    @(posedge clk); #1 rst = 1'b0; en = 1'b1;

    align(); grab(5);
    chk("g0_frame", f0, 1); chk("g0_grid", g0, 0);
    chk("g0_lat_clks", n_lat, 3); chk("g0_blk_clks", n_blk, 10);
    chk("g0_sck_rises", n_sck, 10); chk("g0_gcp_clks", n_gcp, 9);
    chk("g0_gcp_n", q_gcp.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("g0_gcp_at[%0d]", i), (i < q_gcp.size()) ? q_gcp[i] : -1, 16 * (i + 1));
    chk("g0_reads", q_addr.size(), 6);
    chk("g0_addr0", (q_addr.size() > 0) ? q_addr[0] : -1, 0);

    align(); grab(5);
    chk("g1_frame", f0, 0); chk("g1_grid", g0, 1); chk("g1_blk_clks", n_blk, 20);
    for (int i = 0; i < 6; i++)
      chk($sformatf("g1_addr[%0d]", i), (i < q_addr.size()) ? q_addr[i] : -1, 6 + i);
    for (int i = 0; i < 10; i++)
      chk($sformatf("g1_sout[%0d]", i), (i < q_sout.size()) ? q_sout[i] : -1, exp_g1[i]);

    align(); grab(255);
    chk("g2_grid", g0, 2); chk("g2_blk_clks", n_blk, 20);

    align(); grab(255);
    chk("g3_grid", g0, 3); chk("g3_blk_clks", n_blk, 63);
    for (int i = 0; i < 4; i++)
      chk($sformatf("g3_gridbit[%0d]", i), (6 + i < q_sout.size()) ? q_sout[6 + i] : -1, exp_g3[i]);

    align(); grab(0);
    chk("wrap_frame", f0, 1); chk("wrap_grid", g0, 0); chk("wrap_blk_clks", n_blk, 63);
    chk("wrap_addr0", (q_addr.size() > 0) ? q_addr[0] : -1, 0);

    // reset asserted during phase 0 of bit 4
    align();
    repeat (11) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    chk_idle("rst_abort");
    @(posedge clk); #1 rst = 1'b0;
    align();
    chk("rst_restart_frame", frame, 1); chk("rst_restart_grid", grid, 0);
    grab(0);
    chk("rst_restart_addr0", (q_addr.size() > 0) ? q_addr[0] : -1, 0);

    // enable dropped during phase 1 of bit 4
    align();
    repeat (12) @(negedge clk);
    @(posedge clk); #1 en = 1'b0;
    @(negedge clk); @(negedge clk);
    chk_idle("en_abort");
    @(posedge clk); #1 en = 1'b1;
    align();
    chk("en_restart_frame", frame, 1); chk("en_restart_grid", grid, 0);
    grab(0);
    chk("en_restart_blk_clks", n_blk, 10); chk("en_restart_sck", n_sck, 10);

    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
